// File: rtl/enc_bundle_seq_if.sv
// Bus bundle between the bundling sequencer and its surroundings: start/busy control,
// encoder-memory read port, per-dimension bundler path and query hypervector handshake.
interface enc_bundle_seq_if #(
    parameter int FEATURE_COUNT = 617,
    parameter int DIM           = 1024,
    parameter int DIM_W         = $clog2(DIM + 1)
);
    logic                     start;
    logic [DIM_W-1:0]         active_dims;
    logic                     busy;
    logic                     mem_rd_en;
    logic [DIM_W-1:0]         mem_rd_addr;
    logic [FEATURE_COUNT-1:0] mem_rd_data;
    logic [FEATURE_COUNT-1:0] bundle_bits;
    logic                     bundling_features;
    logic                     thresholded_bit;
    logic [DIM-1:0]           hv_out;
    logic                     hv_valid;
    logic                     hv_ready;

    // Sequencer view.
    modport master (
        input  start, active_dims, mem_rd_data, thresholded_bit, hv_ready,
        output busy, mem_rd_en, mem_rd_addr, bundle_bits, bundling_features, hv_out, hv_valid
    );

    // Environment view: memory, bundler, controller and consumer.
    modport slave (
        output start, active_dims, mem_rd_data, thresholded_bit, hv_ready,
        input  busy, mem_rd_en, mem_rd_addr, bundle_bits, bundling_features, hv_out, hv_valid
    );
endinterface

// File: rtl/enc_bundle_seq.sv
// Encoder bundling sequencer: walks the first n dimensions one per cycle, feeds each memory
// slice to the bundler and collects the thresholded bits into the query hypervector.
module enc_bundle_seq #(
    parameter int FEATURE_COUNT = 617,
    parameter int DIM           = 1024,
    parameter int DIM_W         = $clog2(DIM + 1)
) (
    input  logic              clk,
    input  logic              rst,
    enc_bundle_seq_if.master  bus
);
    localparam int AW = (DIM > 1) ? $clog2(DIM) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        OUT
    } state_t;

    state_t           state_q, state_d;
    logic [DIM_W-1:0] n_q;
    logic [DIM_W-1:0] cnt_q;
    logic             cap_valid_q;
    logic [AW-1:0]    cap_addr_q;
    logic [DIM-1:0]   hv_q;

    logic             accept;
    logic             issue;
    logic             last_issue;
    logic [DIM_W-1:0] n_clamped;

    // Pruning count beyond the vector length means "use every dimension".
    assign n_clamped  = (bus.active_dims > DIM_W'(DIM)) ? DIM_W'(DIM) : bus.active_dims;
    assign accept     = (state_q == IDLE) && bus.start;
    assign issue      = (state_q == RUN);
    assign last_issue = issue && (cnt_q == n_q - DIM_W'(1));

    always_comb begin
        // NOTE: next state defaults to the current one so no path through the case infers a latch.
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.start) state_d = (n_clamped != '0) ? RUN : DRAIN;
            RUN:     if (last_issue) state_d = DRAIN;
            DRAIN:   state_d = OUT;
            OUT:     if (bus.hv_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            n_q         <= '0;
            cnt_q       <= '0;
            cap_valid_q <= 1'b0;
            cap_addr_q  <= '0;
            hv_q        <= '0;
        end else begin
            state_q     <= state_d;
            cap_valid_q <= issue;
            cap_addr_q  <= cnt_q[AW-1:0];
            if (accept) begin
                n_q   <= n_clamped;
                cnt_q <= '0;
                hv_q  <= '0;
            end else if (issue) begin
                cnt_q <= cnt_q + DIM_W'(1);
            end
            // Read data arrives one cycle after the request; the bundler answers in that same cycle.
            if (cap_valid_q) begin
                hv_q[cap_addr_q] <= bus.thresholded_bit;
            end
        end
    end

    assign bus.busy              = (state_q != IDLE);
    assign bus.mem_rd_en         = issue;
    assign bus.mem_rd_addr       = issue ? cnt_q : '0;
    assign bus.bundle_bits       = cap_valid_q ? bus.mem_rd_data : '0;
    assign bus.bundling_features = cap_valid_q;
    assign bus.hv_out            = hv_q;
    assign bus.hv_valid          = (state_q == OUT);
endmodule
